// File: rtl/dir_button_debouncer_if.sv
// Signal bundle between the direction-button debouncer and its environment.
// The master drives the raw buttons and divided tick level; the slave is the debouncer.
interface dir_button_debouncer_if;
    logic [3:0] btn_raw;
    logic       clk_debounce;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [1:0] dir;
    logic       dir_changed;

    modport master (
        output btn_raw,
        output clk_debounce,
        input  btn_level,
        input  btn_press,
        input  dir,
        input  dir_changed
    );

    modport slave (
        input  btn_raw,
        input  clk_debounce,
        output btn_level,
        output btn_press,
        output dir,
        output dir_changed
    );
endinterface

// File: rtl/dir_button_debouncer.sv
// Debounces four direction buttons on ticks derived from clk_debounce rising edges and
// tracks the snake heading, refusing direct reversals. All outputs are registered.
module dir_button_debouncer #(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned CNT_W        = 3
) (
    input logic                   clk_in,
    input logic                   reset,
    dir_button_debouncer_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_TICKS - 1);

    localparam logic [1:0] DirRight = 2'b00;
    localparam logic [1:0] DirLeft  = 2'b01;
    localparam logic [1:0] DirUp    = 2'b10;
    localparam logic [1:0] DirDown  = 2'b11;

    logic [3:0]       btn_s1_q, btn_sync_q;
    logic             cd_s1_q, cd_sync_q, cd_hist_q;
    logic             tick;

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       level_q, level_d;
    logic [3:0]       press_q, press_d;
    logic [1:0]       dir_q, dir_d;
    logic             dir_changed_q, dir_changed_d;
    logic [1:0]       cand;

    // clk_debounce is only ever sampled as data; its rising edge becomes a one-cycle tick.
    assign tick = cd_sync_q & ~cd_hist_q;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (btn_sync_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        press_d = level_d & ~level_q;
    end

    always_comb begin
        cand = dir_q;
        if (press_q[3]) begin
            cand = DirUp;
        end else if (press_q[2]) begin
            cand = DirDown;
        end else if (press_q[1]) begin
            cand = DirLeft;
        end else if (press_q[0]) begin
            cand = DirRight;
        end
    end

    // Opposite headings differ only in bit 0, so a reversal is dir_q ^ 2'b01.
    always_comb begin
        dir_d         = dir_q;
        dir_changed_d = 1'b0;
        if ((|press_q) && (cand != dir_q) && (cand != (dir_q ^ 2'b01))) begin
            dir_d         = cand;
            dir_changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            btn_s1_q      <= '0;
            btn_sync_q    <= '0;
            cd_s1_q       <= 1'b0;
            cd_sync_q     <= 1'b0;
            cd_hist_q     <= 1'b0;
            cnt_q         <= '{default: '0};
            level_q       <= '0;
            press_q       <= '0;
            dir_q         <= DirRight;
            dir_changed_q <= 1'b0;
        end else begin
            btn_s1_q      <= bus.btn_raw;
            btn_sync_q    <= btn_s1_q;
            cd_s1_q       <= bus.clk_debounce;
            cd_sync_q     <= cd_s1_q;
            cd_hist_q     <= cd_sync_q;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            press_q       <= press_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.dir         = dir_q;
    assign bus.dir_changed = dir_changed_q;

endmodule

// File: tb/tb_dir_button_debouncer.sv
// Directed bench for dir_button_debouncer: clk_debounce period is 8 clk_in cycles,
// expected debounce timing and headings are hand-derived.
module tb_dir_button_debouncer;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ph      = 7;

    always #5 clk_in = ~clk_in;

    dir_button_debouncer_if bus ();

    dir_button_debouncer #(
        .STABLE_TICKS(4),
        .CNT_W       (3)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clk_in cycle; clk_debounce updates just after the edge, and the
    // caller resumes mid-cycle where it may sample outputs and change inputs.
    task automatic cyc();
        @(posedge clk_in);
        #1;
        ph = (ph + 1) % 8;
        bus.clk_debounce = (ph < 4);
        #4;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Return in the cycle where clk_debounce has just risen.
    task automatic align();
        cyc();
        while (ph != 0) cyc();
    endtask

    // Aligned press: level rises 27 edges after the raw change, dir follows one cycle later.
    task automatic press_seq(input logic [3:0] mask, input logic [3:0] exp_press,
                             input logic [1:0] exp_dir, input logic exp_dc, input string tag);
        int dc_cnt;
        dc_cnt = 0;
        align();
        bus.btn_raw = mask;
        for (int k = 1; k <= 29; k++) begin
            cyc();
            if (bus.dir_changed) dc_cnt++;
            if (k == 26) check({tag, "_level_early"}, 8'(bus.btn_level), 8'h0);
            if (k == 27) begin
                check({tag, "_level"}, 8'(bus.btn_level), 8'(mask));
                check({tag, "_press"}, 8'(bus.btn_press), 8'(exp_press));
            end
            if (k == 28) begin
                check({tag, "_press_end"}, 8'(bus.btn_press), 8'h0);
                check({tag, "_dir"}, 8'(bus.dir), 8'(exp_dir));
                check({tag, "_dc"}, 8'(bus.dir_changed), 8'(exp_dc));
            end
        end
        check({tag, "_dc_count"}, 8'(dc_cnt), 8'(exp_dc));
    endtask

    task automatic release_all(input logic [1:0] exp_dir, input string tag);
        int pr_cnt;
        pr_cnt = 0;
        bus.btn_raw = 4'b0000;
        for (int k = 0; k < 48; k++) begin
            cyc();
            if (|bus.btn_press) pr_cnt++;
        end
        check({tag, "_rel_level"}, 8'(bus.btn_level), 8'h0);
        check({tag, "_rel_press"}, 8'(pr_cnt), 8'h0);
        check({tag, "_rel_dir"}, 8'(bus.dir), 8'(exp_dir));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_seen;
        int pr_cnt;
        bus.btn_raw      = 4'b1111;
        bus.clk_debounce = 1'b0;

        // 1. Reset with all buttons raw-pressed.
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("rst_level", 8'(bus.btn_level), 8'h0);
            check("rst_press", 8'(bus.btn_press), 8'h0);
            check("rst_dir", 8'(bus.dir), 8'h0);
            check("rst_dc", 8'(bus.dir_changed), 8'h0);
        end
        reset       = 1'b0;
        bus.btn_raw = 4'b0000;
        run(20);
        check("idle_level", 8'(bus.btn_level), 8'h0);

        // 2. Up from right.
        press_seq(4'b1000, 4'b1000, 2'b10, 1'b1, "up");
        check("up_dc_off", 8'(bus.dir_changed), 8'h0);
        release_all(2'b10, "up");

        // 3. Bouncing down button never settles.
        hi_seen = 0;
        pr_cnt  = 0;
        for (int k = 0; k < 100; k++) begin
            if (k % 12 == 0) bus.btn_raw[2] = ~bus.btn_raw[2];
            cyc();
            if (bus.btn_level[2]) hi_seen++;
            if (|bus.btn_press) pr_cnt++;
        end
        check("bounce_level", 8'(hi_seen), 8'h0);
        check("bounce_press", 8'(pr_cnt), 8'h0);
        check("bounce_dir", 8'(bus.dir), 8'h2);
        release_all(2'b10, "bounce");

        // 4. Return to right, then left is a reversal and is ignored.
        press_seq(4'b0001, 4'b0001, 2'b00, 1'b1, "right");
        release_all(2'b00, "right");
        press_seq(4'b0010, 4'b0010, 2'b00, 1'b0, "left_rev");
        align();
        bus.btn_raw = 4'b0000;
        pr_cnt = 0;
        for (int k = 1; k <= 28; k++) begin
            cyc();
            if (|bus.btn_press) pr_cnt++;
            if (k == 26) check("left_fall_early", 8'(bus.btn_level), 8'h2);
            if (k == 27) check("left_fall", 8'(bus.btn_level), 8'h0);
        end
        check("left_fall_press", 8'(pr_cnt), 8'h0);
        check("left_fall_dir", 8'(bus.dir), 8'h0);

        // 5. Up to get a legal path to left, then up+right together from left.
        press_seq(4'b1000, 4'b1000, 2'b10, 1'b1, "up2");
        release_all(2'b10, "up2");
        press_seq(4'b0010, 4'b0010, 2'b01, 1'b1, "left");
        release_all(2'b01, "left");
        press_seq(4'b1001, 4'b1001, 2'b10, 1'b1, "up_right");
        release_all(2'b10, "up_right");

        // 6. Reset after two ticks discards the partial count.
        align();
        bus.btn_raw = 4'b0100;
        for (int k = 1; k <= 45; k++) begin
            cyc();
            if (k == 12) reset = 1'b1;
            if (k == 13) begin
                reset = 1'b0;
                check("mid_rst_dir", 8'(bus.dir), 8'h0);
                check("mid_rst_level", 8'(bus.btn_level), 8'h0);
            end
            if (k == 27) check("mid_rst_no_early", 8'(bus.btn_level), 8'h0);
            if (k == 42) check("mid_rst_level_42", 8'(bus.btn_level), 8'h0);
            if (k == 43) begin
                check("mid_rst_level_43", 8'(bus.btn_level), 8'h4);
                check("mid_rst_press", 8'(bus.btn_press), 8'h4);
            end
            if (k == 44) begin
                check("mid_rst_dir_down", 8'(bus.dir), 8'h3);
                check("mid_rst_dc", 8'(bus.dir_changed), 8'h1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
